// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS control sequencer.
// Moore FSM that steps the shared-memory datapath through fetch, decode,
// execute, memory and write-back. It counts retired instructions and flags
// unsupported opcodes.
module mips_multicycle_control #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       opcode,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             PCWrite,
   output logic             PCWriteCond,
   output logic             IorD,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             MemtoReg,
   output logic             IRWrite,
   output logic             RegWrite,
   output logic             RegDst,
   output logic             ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [1:0]       ALUOp,
   output logic [1:0]       PCSource,
   output logic [3:0]       state_dbg,
   output logic             illegal_op,
   output logic [CNT_W-1:0] instr_retired
);

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADDR = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXEC    = 4'd6,
      S_RWB     = 4'd7,
      S_BRANCH  = 4'd8,
      S_JUMP    = 4'd9,
      S_ADDIEX  = 4'd10,
      S_ADDIWB  = 4'd11
   } state_t;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       ir_write;
      logic       reg_write;
      logic       reg_dst;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
   } ctl_t;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;

   // Moore part of the datapath controls for a given state; the FETCH
   // IRWrite/PCWrite terms depend on mem_ready and are added later.
   function automatic ctl_t state_ctl(input state_t st);
      ctl_t c;
      c = '0;
      case (st)
         S_FETCH: begin
            c.mem_read  = 1'b1;
            c.alu_src_b = 2'b01;
         end
         S_DECODE:  c.alu_src_b = 2'b11;
         S_MEMADDR, S_ADDIEX: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'b10;
         end
         S_MEMRD: begin
            c.mem_read = 1'b1;
            c.i_or_d   = 1'b1;
         end
         S_MEMWR: begin
            c.mem_write = 1'b1;
            c.i_or_d    = 1'b1;
         end
         S_MEMWB: begin
            c.reg_write  = 1'b1;
            c.mem_to_reg = 1'b1;
         end
         S_EXEC: begin
            c.alu_src_a = 1'b1;
            c.alu_op    = 2'b10;
         end
         S_RWB: begin
            c.reg_write = 1'b1;
            c.reg_dst   = 1'b1;
         end
         S_ADDIWB:  c.reg_write = 1'b1;
         S_BRANCH: begin
            c.alu_src_a     = 1'b1;
            c.alu_op        = 2'b01;
            c.pc_write_cond = 1'b1;
            c.pc_source     = 2'b01;
         end
         S_JUMP: begin
            c.pc_write  = 1'b1;
            c.pc_source = 2'b10;
         end
         default:   c = '0;
      endcase
      return c;
   endfunction

   state_t           r_state;
   ctl_t             r_ctl;
   logic [CNT_W-1:0] r_instr_retired;
   state_t           w_next_state;
   logic             w_retire;
   logic             w_supported;
   logic             w_state_legal;
   ctl_t             w_ctl;
   logic             w_unused_zero;

   // The branch decision is made in the datapath; zero is only observed here.
   assign w_unused_zero = zero;

   // Opcode support check used by DECODE and the illegal-opcode flag.
   always_comb begin
      w_supported = 1'b0;
      case (opcode)
         OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: w_supported = 1'b1;
         default:                                   w_supported = 1'b0;
      endcase
   end

   // Next-state selection and retirement detection.
   always_comb begin
      w_next_state = S_FETCH;
      w_retire     = 1'b0;
      case (r_state)
         S_FETCH:   w_next_state = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: w_next_state = S_MEMADDR;
               OP_R:         w_next_state = S_EXEC;
               OP_BEQ:       w_next_state = S_BRANCH;
               OP_J:         w_next_state = S_JUMP;
               OP_ADDI:      w_next_state = S_ADDIEX;
               default:      w_next_state = S_FETCH;
            endcase
         end
         S_MEMADDR: w_next_state = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:   w_next_state = mem_ready ? S_MEMWB : S_MEMRD;
         S_MEMWR: begin
            w_next_state = mem_ready ? S_FETCH : S_MEMWR;
            w_retire     = mem_ready;
         end
         S_EXEC:    w_next_state = S_RWB;
         S_ADDIEX:  w_next_state = S_ADDIWB;
         S_MEMWB, S_RWB, S_ADDIWB, S_BRANCH, S_JUMP: begin
            w_next_state = S_FETCH;
            w_retire     = 1'b1;
         end
         default:   w_next_state = S_FETCH;
      endcase
   end

   // State, registered control vector (decoded for the state being entered)
   // and retired-instruction counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state         <= S_FETCH;
         r_ctl           <= state_ctl(S_FETCH);
         r_instr_retired <= '0;
      end else begin
         r_state <= w_next_state;
         r_ctl   <= state_ctl(w_next_state);
         if (w_retire) begin
            r_instr_retired <= r_instr_retired + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            r_instr_retired <= r_instr_retired;
         end
      end
   end

   assign w_state_legal = (r_state <= S_ADDIWB);

   // Final control vector: silence everything in unused encodings, kill the
   // strobes while reset is held, and add the FETCH mem_ready terms.
   always_comb begin
      w_ctl = r_ctl;
      if (!w_state_legal) begin
         w_ctl = '0;
      end else if (reset) begin
         w_ctl.pc_write      = 1'b0;
         w_ctl.pc_write_cond = 1'b0;
         w_ctl.mem_read      = 1'b0;
         w_ctl.mem_write     = 1'b0;
         w_ctl.ir_write      = 1'b0;
         w_ctl.reg_write     = 1'b0;
      end else begin
         w_ctl.pc_write = r_ctl.pc_write | ((r_state == S_FETCH) & mem_ready);
         w_ctl.ir_write = r_ctl.ir_write | ((r_state == S_FETCH) & mem_ready);
      end
   end

   assign PCWrite       = w_ctl.pc_write;
   assign PCWriteCond   = w_ctl.pc_write_cond;
   assign IorD          = w_ctl.i_or_d;
   assign MemRead       = w_ctl.mem_read;
   assign MemWrite      = w_ctl.mem_write;
   assign MemtoReg      = w_ctl.mem_to_reg;
   assign IRWrite       = w_ctl.ir_write;
   assign RegWrite      = w_ctl.reg_write;
   assign RegDst        = w_ctl.reg_dst;
   assign ALUSrcA       = w_ctl.alu_src_a;
   assign ALUSrcB       = w_ctl.alu_src_b;
   assign ALUOp         = w_ctl.alu_op;
   assign PCSource      = w_ctl.pc_source;
   assign state_dbg     = r_state;
   assign illegal_op    = ~reset & (r_state == S_DECODE) & ~w_supported;
   assign instr_retired = r_instr_retired;

endmodule
